// File: rtl/microwave_timer.sv
`default_nettype none
// ============================================================================
// Module   : microwave_timer
// Purpose  : Countdown timer for the microwave controller. Digits are shifted
//            into a 4-digit BCD MM:SS register while the magnetron is off.
//            While cooking, the count decrements once per second. timer_done
//            tells the panel control logic that the count is empty.
// Ports    : clk        - system clock, rising edge
//            resetn     - asynchronous active-low reset
//            clearn     - synchronous active-low clear of the entered time
//            mag_on     - magnetron latch state (1 = cooking)
//            key_valid  - single-cycle keypad strobe
//            key_digit  - BCD digit accompanying key_valid
//            time_bcd   - {M10, M1, S10, S1}, registered
//            timer_done - registered, 1 when the count is 0000
//            running    - registered, 1 while counting down
// Revision : 1.0 - initial release
// ============================================================================
module microwave_timer #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int PRESC_W       = 26
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        clearn,
   input  logic        mag_on,
   input  logic        key_valid,
   input  logic [3:0]  key_digit,
   output logic [15:0] time_bcd,
   output logic        timer_done,
   output logic        running
);

   localparam logic [PRESC_W-1:0] C_PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [15:0]          count_q, count_d;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic                 timer_done_q, timer_done_d;
   logic                 running_q, running_d;

   logic                 tick;
   logic                 key_ok;
   logic [15:0]          count_dec;

   // One-second decrement of an MM:SS BCD value. Seconds above 59 simply
   // count down digit-wise; a seconds borrow reloads 59. 0000 is held.
   function automatic logic [15:0] bcd_dec(input logic [15:0] c);
      logic [3:0] m10, m1, s10, s1;
      m10 = c[15:12];
      m1  = c[11:8];
      s10 = c[7:4];
      s1  = c[3:0];
      if (c == 16'h0000) begin
         return c;
      end
      if (s1 != 4'd0) begin
         s1 = s1 - 4'd1;
      end else begin
         s1 = 4'd9;
         if (s10 != 4'd0) begin
            s10 = s10 - 4'd1;
         end else begin
            s10 = 4'd5;
            if (m1 != 4'd0) begin
               m1 = m1 - 4'd1;
            end else begin
               m1  = 4'd9;
               m10 = m10 - 4'd1;
            end
         end
      end
      return {m10, m1, s10, s1};
   endfunction

   assign tick      = (state_q == S_RUN) && (presc_q == C_PRESC_MAX);
   assign key_ok    = key_valid && !mag_on && (key_digit <= 4'd9);
   assign count_dec = bcd_dec(count_q);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      presc_d = '0;

      if (!clearn) begin
         // Clear wins over everything, including a coincident key.
         state_d = S_IDLE;
         count_d = 16'h0000;
      end else begin
         case (state_q)
            S_RUN: begin
               // A tick is honoured even when mag_on drops on the same cycle.
               if (tick) begin
                  count_d = count_dec;
               end
               if (tick && (count_dec == 16'h0000)) begin
                  state_d = S_DONE;
               end else if (!mag_on) begin
                  state_d = S_IDLE;
               end
            end
            S_IDLE: begin
               if (key_ok) begin
                  count_d = {count_q[11:0], key_digit};
               end else if (mag_on && (count_q != 16'h0000)) begin
                  state_d = S_RUN;
               end
            end
            S_DONE: begin
               if (key_ok) begin
                  count_d = {count_q[11:0], key_digit};
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // Prescaler only advances across consecutive RUN cycles; any exit
      // from RUN discards the partial second.
      if ((state_q == S_RUN) && (state_d == S_RUN)) begin
         presc_d = tick ? '0 : presc_q + PRESC_W'(1);
      end

      timer_done_d = (count_d == 16'h0000);
      running_d    = (state_d == S_RUN);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         count_q      <= 16'h0000;
         presc_q      <= '0;
         timer_done_q <= 1'b1;
         running_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         presc_q      <= presc_d;
         timer_done_q <= timer_done_d;
         running_q    <= running_d;
      end
   end

   assign time_bcd   = count_q;
   assign timer_done = timer_done_q;
   assign running    = running_q;

endmodule
`default_nettype wire
